// File: rtl/sysid_checker_pkg.sv
// Shared definitions for the system ID checker and the sysid slave wrapper.
package sysid_checker_pkg;

  // Checker sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_ID = 3'd1,
    ST_LAT_ID = 3'd2,
    ST_REQ_TS = 3'd3,
    ST_LAT_TS = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Word addresses inside the sysid peripheral.
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Values the stock sysid build reports.
  localparam logic [31:0] DEF_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1579707414;

  // A read strobe is active only in the request states.
  function automatic logic is_req(state_e s);
    return (s == ST_REQ_ID) || (s == ST_REQ_TS);
  endfunction

  // Waiting for read data that the slave has already accepted.
  function automatic logic is_lat(state_e s);
    return (s == ST_LAT_ID) || (s == ST_LAT_TS);
  endfunction

endpackage

// File: rtl/sysid_read_timer.sv
// Per-read timers: a watchdog that bounds the total cycles one read may take
// (stall plus latency) and a short counter that marks when accepted read data
// becomes valid.
module sysid_read_timer
  import sysid_checker_pkg::*;
#(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,     // next cycle is the first cycle of a new read
  input  logic run,         // a read is in flight this cycle
  input  logic lat_load,    // slave accepted the read this cycle
  input  logic lat_run,     // waiting for accepted data this cycle
  output logic to_expire,   // this cycle is the last one the read may use
  output logic lat_expire   // read data is valid this cycle
);

  // Watchdog compares against the index of the final allowed cycle.
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  // Latency counter is loaded on acceptance and hits zero on the data cycle.
  localparam logic [1:0]  LAT_LAST = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  logic [15:0] to_cnt_q, to_cnt_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;

  // to_cnt_q holds how many cycles the current read has already used.
  // Comparing with >= lets an acceptance on the last allowed cycle still
  // expire one cycle later if latency pushes it past the budget.
  assign to_expire  = run && (to_cnt_q >= TO_LAST);
  assign lat_expire = lat_run && (lat_cnt_q == 2'd0);

  // Next-count logic for both timers; the watchdog saturates at expiry.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    lat_cnt_d = lat_cnt_q;
    if (restart) begin
      to_cnt_d = '0;
    end else if (run && !to_expire) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
    if (lat_load) begin
      lat_cnt_d = LAT_LAST;
    end else if (lat_run && (lat_cnt_q != 2'd0)) begin
      lat_cnt_d = lat_cnt_q - 2'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      lat_cnt_q <= '0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the sysid ID word and build timestamp and
// reports whether both match the expected build. Runs once after reset
// (optionally) and again on each start pulse received while idle or done.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam bit NO_LAT = (READ_LATENCY == 0);

  state_e      state_q, state_d;
  logic        auto_pend_q, auto_pend_d;
  logic        timeout_q, timeout_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic in_req, in_lat, rd_acc;
  logic id_cap, ts_cap, clr_status;
  logic tmr_restart, lat_load, to_expire, lat_expire;

  // Bus strobes come straight from the state register, so an asynchronous
  // reset drops avm_read immediately.
  assign in_req      = is_req(state_q);
  assign in_lat      = is_lat(state_q);
  assign avm_read    = in_req;
  assign avm_address = (state_q == ST_REQ_TS) ? ADDR_TS : ADDR_ID;
  assign rd_acc      = in_req && !avm_waitrequest;

  assign busy     = in_req || in_lat;
  assign done     = (state_q == ST_DONE);
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

  sysid_read_timer #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .restart    (tmr_restart),
    .run        (busy),
    .lat_load   (lat_load),
    .lat_run    (in_lat),
    .to_expire  (to_expire),
    .lat_expire (lat_expire)
  );

  // Sequencing: ID read, TS read, done. Data capture wins over the watchdog
  // when both land on the same cycle.
  always_comb begin
    state_d     = state_q;
    auto_pend_d = auto_pend_q;
    timeout_d   = timeout_q;
    id_cap      = 1'b0;
    ts_cap      = 1'b0;
    clr_status  = 1'b0;
    lat_load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (auto_pend_q || start) begin
          state_d     = ST_REQ_ID;
          auto_pend_d = 1'b0;
        end
      end
      ST_REQ_ID: begin
        if (rd_acc) begin
          if (NO_LAT) begin
            id_cap  = 1'b1;
            state_d = ST_REQ_TS;
          end else begin
            lat_load = 1'b1;
            state_d  = ST_LAT_ID;
          end
        end else if (to_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_LAT_ID: begin
        if (lat_expire) begin
          id_cap  = 1'b1;
          state_d = ST_REQ_TS;
        end else if (to_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_REQ_TS: begin
        if (rd_acc) begin
          if (NO_LAT) begin
            ts_cap  = 1'b1;
            state_d = ST_DONE;
          end else begin
            lat_load = 1'b1;
            state_d  = ST_LAT_TS;
          end
        end else if (to_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_LAT_TS: begin
        if (lat_expire) begin
          ts_cap  = 1'b1;
          state_d = ST_DONE;
        end else if (to_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          clr_status = 1'b1;
          timeout_d  = 1'b0;
          state_d    = ST_REQ_ID;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Restart the watchdog whenever a request state is freshly entered.
    tmr_restart = ((state_d == ST_REQ_ID) && (state_q != ST_REQ_ID)) ||
                  ((state_d == ST_REQ_TS) && (state_q != ST_REQ_TS));
  end

  // Capture registers and their registered compares.
  always_comb begin
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    if (clr_status) begin
      id_value_d = '0;
      ts_value_d = '0;
      id_ok_d    = 1'b0;
      ts_ok_d    = 1'b0;
    end
    if (id_cap) begin
      id_value_d = avm_readdata;
      id_ok_d    = (avm_readdata == EXPECTED_ID);
    end
    if (ts_cap) begin
      ts_value_d = avm_readdata;
      ts_ok_d    = (avm_readdata == EXPECTED_TS);
    end
  end

  // State and status registers; reset clears everything and re-arms auto start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      auto_pend_q <= AUTO_START;
      timeout_q   <= 1'b0;
      id_ok_q     <= 1'b0;
      ts_ok_q     <= 1'b0;
      id_value_q  <= '0;
      ts_value_q  <= '0;
    end else begin
      state_q     <= state_d;
      auto_pend_q <= auto_pend_d;
      timeout_q   <= timeout_d;
      id_ok_q     <= id_ok_d;
      ts_ok_q     <= ts_ok_d;
      id_value_q  <= id_value_d;
      ts_value_q  <= ts_value_d;
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker. Instance A (auto start, latency 2, short timeout)
// runs against a stalling slave model with a scoreboard; instance B (manual
// start, latency 0) gets directed cycle-level checks.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1579707414;
  localparam int          LAT_A  = 2;
  localparam int          TO_A   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic        start_a, addr_a, read_a, wr_a, busy_a, done_a, id_ok_a, ts_ok_a, to_a;
  logic [31:0] rd_a, idv_a, tsv_a;

  sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .READ_LATENCY(LAT_A), .TIMEOUT_CYCLES(TO_A), .AUTO_START(1'b1)
  ) dut_a (
    .clock(clk), .reset(rst), .start(start_a),
    .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wr_a),
    .avm_readdata(rd_a), .busy(busy_a), .done(done_a), .id_ok(id_ok_a),
    .ts_ok(ts_ok_a), .timeout(to_a), .id_value(idv_a), .ts_value(tsv_a)
  );

  // ---------------- instance B ----------------
  logic        start_b, addr_b, read_b, busy_b, done_b, id_ok_b, ts_ok_b, to_b;
  logic [31:0] rd_b, idv_b, tsv_b, tsb_val;
  logic        wr_b = 1'b0;

  sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clk), .reset(rst), .start(start_b),
    .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wr_b),
    .avm_readdata(rd_b), .busy(busy_b), .done(done_b), .id_ok(id_ok_b),
    .ts_ok(ts_ok_b), .timeout(to_b), .id_value(idv_b), .ts_value(tsv_b)
  );

  assign rd_b = addr_b ? tsb_val : EXP_ID;

  // ---------------- slave model for A ----------------
  // Stalls each read for a configured number of cycles, then returns the
  // configured word exactly LAT_A cycles after acceptance; junk otherwise.
  int          stall_id_cfg, stall_ts_cfg, stall_cnt;
  logic [31:0] id_val_cfg, ts_val_cfg, junk;
  logic [1:0]  dv, da;
  logic        acc_a;

  assign wr_a  = read_a && (stall_cnt < (addr_a ? stall_ts_cfg : stall_id_cfg));
  assign acc_a = read_a && !wr_a;
  assign rd_a  = dv[1] ? (da[1] ? ts_val_cfg : id_val_cfg) : junk;

  always @(posedge clk) junk <= $urandom;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 0;
      dv        <= '0;
      da        <= '0;
    end else begin
      stall_cnt <= (!read_a || acc_a) ? 0 : stall_cnt + 1;
      dv        <= {dv[0], acc_a};
      da        <= {da[0], addr_a};
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic        id_ok, ts_ok, to;
    logic [31:0] idv, tsv;
    int          rd_cyc, ts_cyc;
  } exp_t;

  exp_t expq[$];
  int   total = 0, passed = 0, runs_done = 0;

  // A read with s stall cycles is accepted on its (s+1)th cycle and its data
  // arrives LAT_A cycles later; the whole read must fit in TO_A cycles.
  function automatic exp_t model(int sid, int sts, logic [31:0] vid, logic [31:0] vts);
    exp_t e;
    e.id_ok = 1'b0; e.ts_ok = 1'b0; e.to = 1'b0;
    e.idv = '0; e.tsv = '0; e.ts_cyc = 0;
    e.rd_cyc = (sid >= TO_A) ? TO_A : sid + 1;
    if (sid + 1 + LAT_A > TO_A) begin e.to = 1'b1; return e; end
    e.idv = vid; e.id_ok = (vid == EXP_ID);
    e.ts_cyc = (sts >= TO_A) ? TO_A : sts + 1;
    e.rd_cyc += e.ts_cyc;
    if (sts + 1 + LAT_A > TO_A) begin e.to = 1'b1; return e; end
    e.tsv = vts; e.ts_ok = (vts == EXP_TS);
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: counts read cycles per run and scores each completed run.
  initial begin
    int   rd_cyc, ts_cyc;
    bit   prev_done;
    exp_t e;
    rd_cyc = 0; ts_cyc = 0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_cyc = 0; ts_cyc = 0; prev_done = 1'b0;
      end else begin
        if (read_a) begin
          rd_cyc++;
          if (addr_a) ts_cyc++;
          if (expq.size() == 0) begin
            total++;
            $display("FAIL unexpected_read: avm_read=1 addr=%0d with no check pending", addr_a);
          end
        end
        if (done_a && !prev_done) begin
          if (expq.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: done rose with no check pending");
          end else begin
            e = expq.pop_front();
            chk("busy_at_done", 32'(busy_a), 32'd0);
            chk("id_ok",        32'(id_ok_a), 32'(e.id_ok));
            chk("ts_ok",        32'(ts_ok_a), 32'(e.ts_ok));
            chk("timeout",      32'(to_a),    32'(e.to));
            chk("id_value",     idv_a, e.idv);
            chk("ts_value",     tsv_a, e.tsv);
            chk("read_cycles",  32'(rd_cyc), 32'(e.rd_cyc));
            chk("ts_read_cycles", 32'(ts_cyc), 32'(e.ts_cyc));
            runs_done++;
          end
          rd_cyc = 0; ts_cyc = 0;
        end
        prev_done = done_a;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic launch(int sid, int sts, logic [31:0] vid, logic [31:0] vts);
    stall_id_cfg = sid; stall_ts_cfg = sts;
    id_val_cfg   = vid; ts_val_cfg   = vts;
    expq.push_back(model(sid, sts, vid, vts));
  endtask

  task automatic pulse_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_run();
    int target, n;
    target = runs_done + 1;
    n = 0;
    while (runs_done < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (runs_done < target) $display("FAIL run_wait: no done within 400 cycles");
    else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int sid, sts, n;
    logic [31:0] vid, vts;
    start_a = 1'b0; start_b = 1'b0; tsb_val = EXP_TS;
    stall_id_cfg = 0; stall_ts_cfg = 0; id_val_cfg = EXP_ID; ts_val_cfg = EXP_TS;

    // Reset values on both instances.
    repeat (3) @(negedge clk);
    chk("rst_a_ctrl", 32'({addr_a, read_a, busy_a, done_a, id_ok_a, ts_ok_a, to_a}), 32'd0);
    chk("rst_a_idv", idv_a, 32'd0);
    chk("rst_a_tsv", tsv_a, 32'd0);
    chk("rst_b_ctrl", 32'({addr_b, read_b, busy_b, done_b, id_ok_b, ts_ok_b, to_b}), 32'd0);

    // Auto start on release with a start pulse in the same cycle: one run only.
    launch(0, 0, EXP_ID, EXP_TS);
    rst = 1'b0; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_run();
    repeat (6) @(negedge clk);
    chk("a_done_held", 32'(done_a), 32'd1);

    // B does nothing until started.
    chk("b_idle_read", 32'(read_b), 32'd0);
    chk("b_idle_busy", 32'(busy_b), 32'd0);

    // B: start, read ID then TS on consecutive cycles, done on the third.
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b1;  // second pulse lands while busy
    chk("b_req_id", 32'({read_b, addr_b}), 32'b10);
    @(negedge clk); start_b = 1'b0;
    chk("b_req_ts", 32'({read_b, addr_b}), 32'b11);
    @(negedge clk);
    chk("b_done", 32'({done_b, busy_b, id_ok_b, ts_ok_b, to_b}), 32'b10110);
    chk("b_ts_value", tsv_b, EXP_TS);
    repeat (3) @(negedge clk);
    chk("b_no_queued_start", 32'({done_b, read_b}), 32'b10);
    // B: restart from done clears status, then reports a timestamp mismatch.
    tsb_val = EXP_TS + 32'd1;
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    chk("b_restart_clear", 32'({done_b, busy_b, id_ok_b, ts_ok_b}), 32'b0100);
    chk("b_restart_tsv", tsv_b, 32'd0);
    repeat (2) @(negedge clk);
    chk("b_rerun", 32'({done_b, id_ok_b, ts_ok_b}), 32'b110);
    chk("b_rerun_tsv", tsv_b, EXP_TS + 32'd1);

    // A: directed runs.
    launch(0, 0, EXP_ID, EXP_TS + 32'd1);   pulse_a(); wait_run();
    launch(4, 0, EXP_ID, EXP_TS);           pulse_a(); wait_run();
    launch(1000, 0, EXP_ID, EXP_TS);        pulse_a(); wait_run();
    launch(TO_A - 1 - LAT_A, 0, EXP_ID, EXP_TS); pulse_a(); wait_run();
    launch(TO_A - LAT_A, 0, EXP_ID, EXP_TS);     pulse_a(); wait_run();
    launch(0, TO_A - 1 - LAT_A, EXP_ID, EXP_TS); pulse_a(); wait_run();
    launch(0, TO_A - LAT_A, EXP_ID, EXP_TS);     pulse_a(); wait_run();

    // A: a start pulse while busy must not cause a second run.
    launch(6, 3, EXP_ID, EXP_TS);
    pulse_a();
    repeat (2) @(negedge clk);
    chk("a_busy_mid_run", 32'(busy_a), 32'd1);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_run();
    repeat (4) @(negedge clk);

    // A: randomized runs.
    for (int i = 0; i < 14; i++) begin
      sid = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 15));
      sts = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 15));
      vid = $urandom_range(0, 1) ? EXP_ID : $urandom;
      vts = $urandom_range(0, 1) ? EXP_TS : $urandom;
      launch(sid, sts, vid, vts);
      pulse_a();
      wait_run();
    end

    // A: asynchronous reset while waiting on timestamp data.
    launch(0, 0, EXP_ID, EXP_TS);
    pulse_a();
    n = 0;
    while (!(read_a && addr_a) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_reached_req_ts", 32'({read_a, addr_a}), 32'b11);
    @(posedge clk); #2;
    rst = 1'b1;
    expq.delete();
    #1;
    chk("a_async_rst_ctrl", 32'({read_a, busy_a, id_ok_a, done_a}), 32'd0);
    chk("a_async_rst_idv", idv_a, 32'd0);
    repeat (2) @(negedge clk);
    launch(0, 0, EXP_ID, EXP_TS);
    rst = 1'b0;
    wait_run();

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
